// File: rtl/pipe_hazard_ctrl.sv
// Pipeline controller for the F/D/A/M core: warm-up, load-use bubbles,
// mispredict flushes, debug halt and a saturating bubble counter.
module pipe_hazard_ctrl #(
  parameter int REGNOBITS = 6,
  parameter int WARMUP    = 4,
  parameter int LDLAT     = 1,
  parameter int CNTBITS   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [REGNOBITS-1:0] rs_D,
  input  logic [REGNOBITS-1:0] rt_D,
  input  logic                 usert_D,
  input  logic                 valid_D,
  input  logic                 ldvalid_A,
  input  logic [REGNOBITS-1:0] wregno_A,
  input  logic                 mispred_B,
  input  logic                 halt_req,
  output logic                 adv,
  output logic                 stall_F,
  output logic                 stall_D,
  output logic                 bubble_A,
  output logic                 flush_D,
  output logic                 halted,
  output logic [1:0]           state,
  output logic [CNTBITS-1:0]   stallcnt
);

  typedef enum logic [1:0] {
    WARM    = 2'b00,
    RUN     = 2'b01,
    LDSTALL = 2'b10,
    HALT    = 2'b11
  } st_t;

  localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int LW = (LDLAT > 2) ? $clog2(LDLAT - 1) : 1;
  localparam logic [WW-1:0] WINIT = WW'(WARMUP - 1);
  localparam logic [LW-1:0] LINIT = LW'((LDLAT > 1) ? (LDLAT - 2) : 0);

  st_t           st_q, st_n, cur;
  logic [WW-1:0] wcnt_q, wcnt_n;
  logic [LW-1:0] lcnt_q, lcnt_n;
  logic          loadhaz;

  // Outputs follow WARM while reset is held, whatever the stored state.
  assign cur   = reset ? WARM : st_q;
  assign state = cur;

  assign loadhaz = ldvalid_A & valid_D &
                   ((wregno_A == rs_D) |
                    (usert_D & (wregno_A == rt_D)));

  always_comb begin
    adv      = tick & (cur != HALT);
    stall_F  = 1'b0;
    stall_D  = 1'b0;
    bubble_A = 1'b0;
    flush_D  = 1'b0;
    halted   = 1'b0;
    st_n     = st_q;
    wcnt_n   = wcnt_q;
    lcnt_n   = lcnt_q;
    unique case (cur)
      WARM: begin
        stall_F  = 1'b1;
        bubble_A = 1'b1;
        flush_D  = 1'b1;
        if (adv) begin
          if (wcnt_q == '0) st_n = RUN;
          else wcnt_n = wcnt_q - WW'(1);
        end
      end
      RUN: begin
        if (mispred_B) begin
          flush_D = 1'b1;
        end else if (loadhaz) begin
          stall_F  = 1'b1;
          stall_D  = 1'b1;
          bubble_A = 1'b1;
          if (adv && LDLAT > 1) begin
            st_n   = LDSTALL;
            lcnt_n = LINIT;
          end
        end else if (halt_req) begin
          if (adv) st_n = HALT;
        end
      end
      LDSTALL: begin
        stall_F  = 1'b1;
        stall_D  = 1'b1;
        bubble_A = 1'b1;
        if (adv) begin
          if (lcnt_q == '0) st_n = RUN;
          else lcnt_n = lcnt_q - LW'(1);
        end
      end
      HALT: begin
        halted = 1'b1;
        // Exit cycle does not advance; pipeline resumes next cycle.
        if (tick && !halt_req) st_n = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= WARM;
      wcnt_q <= WINIT;
      lcnt_q <= '0;
    end else begin
      st_q   <= st_n;
      wcnt_q <= wcnt_n;
      lcnt_q <= lcnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stallcnt <= '0;
    end else if (adv && bubble_A && cur != WARM
                 && stallcnt != {CNTBITS{1'b1}}) begin
      stallcnt <= stallcnt + CNTBITS'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three instances (LDLAT=1,
// LDLAT=3, 4-bit counter) checked through an expectation queue.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset, tick, usert_D, valid_D;
  logic       ldvalid_A, mispred_B, halt_req;
  logic [5:0] rs_D, rt_D, wregno_A;

  logic        adv_o [3];
  logic        sf_o  [3];
  logic        sd_o  [3];
  logic        ba_o  [3];
  logic        fd_o  [3];
  logic        h_o   [3];
  logic [1:0]  st_o  [3];
  logic [15:0] c0, c1;
  logic [3:0]  c2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    int          id;
    logic [7:0]  f;
    logic [7:0]  m;
    logic [15:0] c;
    bit          cc;
  } exp_t;

  exp_t q[$];

  // {adv, stall_F, stall_D, bubble_A, flush_D, halted, state}
  localparam logic [7:0] WRM   = 8'b1101_1000;
  localparam logic [7:0] RUNI  = 8'b1000_0001;
  localparam logic [7:0] RUNI0 = 8'b0000_0001;
  localparam logic [7:0] RSTL  = 8'b1111_0001;
  localparam logic [7:0] RSTL0 = 8'b0111_0001;
  localparam logic [7:0] RFL   = 8'b1000_1001;
  localparam logic [7:0] LDS   = 8'b1111_0010;
  localparam logic [7:0] HLT   = 8'b0000_0111;
  localparam logic [7:0] ALL   = 8'hff;
  localparam logic [7:0] NOST  = 8'hfc;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REGNOBITS(6), .WARMUP(4), .LDLAT(1), .CNTBITS(16)) d1 (
    .clk(clk), .reset(reset), .tick(tick), .rs_D(rs_D), .rt_D(rt_D),
    .usert_D(usert_D), .valid_D(valid_D), .ldvalid_A(ldvalid_A),
    .wregno_A(wregno_A), .mispred_B(mispred_B), .halt_req(halt_req),
    .adv(adv_o[0]), .stall_F(sf_o[0]), .stall_D(sd_o[0]),
    .bubble_A(ba_o[0]), .flush_D(fd_o[0]), .halted(h_o[0]),
    .state(st_o[0]), .stallcnt(c0));

  pipe_hazard_ctrl #(.REGNOBITS(6), .WARMUP(4), .LDLAT(3), .CNTBITS(16)) d3 (
    .clk(clk), .reset(reset), .tick(tick), .rs_D(rs_D), .rt_D(rt_D),
    .usert_D(usert_D), .valid_D(valid_D), .ldvalid_A(ldvalid_A),
    .wregno_A(wregno_A), .mispred_B(mispred_B), .halt_req(halt_req),
    .adv(adv_o[1]), .stall_F(sf_o[1]), .stall_D(sd_o[1]),
    .bubble_A(ba_o[1]), .flush_D(fd_o[1]), .halted(h_o[1]),
    .state(st_o[1]), .stallcnt(c1));

  pipe_hazard_ctrl #(.REGNOBITS(6), .WARMUP(4), .LDLAT(1), .CNTBITS(4)) d4 (
    .clk(clk), .reset(reset), .tick(tick), .rs_D(rs_D), .rt_D(rt_D),
    .usert_D(usert_D), .valid_D(valid_D), .ldvalid_A(ldvalid_A),
    .wregno_A(wregno_A), .mispred_B(mispred_B), .halt_req(halt_req),
    .adv(adv_o[2]), .stall_F(sf_o[2]), .stall_D(sd_o[2]),
    .bubble_A(ba_o[2]), .flush_D(fd_o[2]), .halted(h_o[2]),
    .state(st_o[2]), .stallcnt(c2));

  function automatic logic [7:0] obs(int id);
    return {adv_o[id], sf_o[id], sd_o[id], ba_o[id],
            fd_o[id], h_o[id], st_o[id]};
  endfunction

  function automatic logic [15:0] cnt(int id);
    if (id == 0) return c0;
    if (id == 1) return c1;
    return {12'd0, c2};
  endfunction

  task automatic push(string tag, int id, logic [7:0] f, logic [15:0] c,
                      logic [7:0] m = ALL, bit cc = 1'b1);
    exp_t e;
    e.tag = tag; e.id = id; e.f = f; e.m = m; e.c = c; e.cc = cc;
    q.push_back(e);
  endtask

  // Compare all pending expectations mid-cycle, then move to next negedge.
  task automatic step();
    exp_t        e;
    logic [7:0]  g;
    logic [15:0] gc;
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      g = obs(e.id);
      total++;
      assert ((g & e.m) === (e.f & e.m)) else begin
        bad++;
        $error("FAIL %s dut%0d flags got=%b exp=%b",
               e.tag, e.id, g & e.m, e.f & e.m);
      end
      if (e.cc) begin
        gc = cnt(e.id);
        total++;
        assert (gc === e.c) else begin
          bad++;
          $error("FAIL %s dut%0d stallcnt got=%0d exp=%0d",
                 e.tag, e.id, gc, e.c);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_in();
    tick = 1'b1; usert_D = 1'b0; valid_D = 1'b0; ldvalid_A = 1'b0;
    mispred_B = 1'b0; halt_req = 1'b0;
    rs_D = '0; rt_D = '0; wregno_A = '0;
  endtask

  task automatic reset_warm();
    clear_in();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) push("in_reset", i, WRM, 0, NOST, 1'b0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 3; i++) push("warm", i, WRM, 0);
    step(); step(); step(); step();
    for (int i = 0; i < 3; i++) push("warm_done", i, RUNI, 0);
    step();
  endtask

  task automatic haz_rs5();
    ldvalid_A = 1'b1; wregno_A = 6'd5; rs_D = 6'd5; valid_D = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    clear_in();
    reset_warm();

    // LDLAT=1 on d1
    haz_rs5();
    push("ld_rs", 0, RSTL, 0); step();
    rs_D = 6'd3; rt_D = 6'd5; usert_D = 1'b0;
    push("rt_unused", 0, RUNI, 1); step();
    usert_D = 1'b1;
    push("ld_rt", 0, RSTL, 1); step();
    valid_D = 1'b0;
    push("nop_D", 0, RUNI, 2); step();
    valid_D = 1'b1; rs_D = 6'd5; mispred_B = 1'b1;
    push("mp_over_haz", 0, RFL, 2); step();
    mispred_B = 1'b0; tick = 1'b0;
    push("tick0_haz", 0, RSTL0, 2); step();
    ldvalid_A = 1'b0;
    push("tick0_idle", 0, RUNI0, 2); step();

    // halt and resume on d1
    tick = 1'b1; halt_req = 1'b1;
    push("halt_req", 0, RUNI, 2); step();
    push("halted", 0, HLT, 2); step();
    halt_req = 1'b0; tick = 1'b0;
    push("halt_frozen", 0, HLT, 2); step();
    tick = 1'b1;
    push("halt_exit", 0, HLT, 2); step();
    push("resumed", 0, RUNI, 2); step();
    halt_req = 1'b1;
    push("halt_req2", 0, RUNI, 2); step();
    push("halted2", 0, HLT, 2); step();
    reset = 1'b1;
    push("rst_in_halt", 0, WRM, 0, NOST, 1'b0); step();
    reset = 1'b0; halt_req = 1'b0;
    push("post_rst_halt", 0, WRM, 0); step();

    // LDLAT=3 on d3
    reset_warm();
    haz_rs5();
    push("l3_n", 1, RSTL, 0); step();
    mispred_B = 1'b1;
    push("l3_n1_mp", 1, LDS, 1); step();
    push("l3_n2_mp", 1, LDS, 2); step();
    mispred_B = 1'b0; ldvalid_A = 1'b0;
    push("l3_done", 1, RUNI, 3); step();
    ldvalid_A = 1'b1;
    push("l3_again", 1, RSTL, 3); step();
    push("l3_mid", 1, LDS, 4); step();
    reset = 1'b1;
    push("rst_in_lds", 1, WRM, 0, NOST, 1'b0); step();
    reset = 1'b0; ldvalid_A = 1'b0;
    push("post_rst_lds", 1, WRM, 0); step();

    // saturation on the 4-bit counter
    reset_warm();
    haz_rs5();
    for (int i = 0; i < 20; i++) begin
      push("sat4", 2, RSTL, 16'((i > 15) ? 15 : i));
      push("cnt16", 0, RSTL, 16'(i));
      step();
    end
    ldvalid_A = 1'b0;
    push("sat4_hold", 2, RUNI, 15);
    push("cnt16_end", 0, RUNI, 20);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
